// File: rtl/aes_decrypt_core_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_decrypt_core_pkg
// Purpose  : Shared AES definitions for the inverse-cipher datapath: round
//            count, FSM state encodings, GF(2^8) multiply-by-constant helpers
//            (xtime chain) and row/column byte-slice helpers for the
//            row-major 128-bit state layout.
// Layout   : byte (row r, column c) lives at bits [8*(15-(4r+c)) +: 8],
//            i.e. [127:96] is row 0 and the MSB byte of a row is column 0.
// Revision : 1.0 - initial release
// ============================================================================
package aes_decrypt_core_pkg;

  localparam int AES128_NR = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // LSB position of byte (r, c) inside the 128-bit row-major state.
  function automatic logic [6:0] byte_lsb(input int r, input int c);
    return 7'(8 * (15 - (4 * r + c)));
  endfunction

  // Row r is rotated right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[byte_lsb(r, (c + r) % 4) +: 8] = st[byte_lsb(r, c) +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[byte_lsb(0, c) +: 8];
      a1 = st[byte_lsb(1, c) +: 8];
      a2 = st[byte_lsb(2, c) +: 8];
      a3 = st[byte_lsb(3, c) +: 8];
      res[byte_lsb(0, c) +: 8] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
      res[byte_lsb(1, c) +: 8] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
      res[byte_lsb(2, c) +: 8] = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
      res[byte_lsb(3, c) +: 8] = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sbox
// Purpose  : AES inverse S-box, combinational 256-entry byte lookup.
// Ports    : in_byte  (in,  8) - byte to substitute
//            out_byte (out, 8) - InvSubBytes(in_byte)
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 is the most significant byte of the table.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // 8*(255 - in_byte) is simply the inverted byte shifted left by 3.
  assign out_byte = INV_SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core
// Purpose  : Iterative AES-128 inverse cipher, one round per clock, with
//            valid/ready handshakes on both sides and an external
//            expanded-key store read combinationally by round index.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            in_valid/ready  - ciphertext handshake (ready only when idle)
//            in_data  [127:0]- ciphertext, row-major state layout
//            key_idx  [KIDX_W-1:0] - round key requested this cycle
//            key_data [127:0]- round key for key_idx, same layout
//            out_valid/ready - plaintext handshake
//            out_data [127:0]- plaintext, held until out_ready
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_core
  import aes_decrypt_core_pkg::*;
#(
  parameter int NR     = AES128_NR,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      key_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data
);

  localparam logic [KIDX_W-1:0] KEY_FIRST = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] RND_START = KIDX_W'(NR - 1);
  localparam logic [KIDX_W-1:0] RND_ONE   = KIDX_W'(1);

  logic [1:0]        fsm_q, fsm_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  logic [127:0]      state_q, state_d;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Round datapath shared by ROUND and FINAL; FINAL simply skips the mix.
  assign shifted = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (shifted[8*i +: 8]),
      .out_byte (subbed[8*i +: 8])
    );
  end

  assign keyed = subbed ^ key_data;
  assign mixed = inv_mix_columns(keyed);

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ key_data;
          rnd_d   = RND_START;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = mixed;
        if (rnd_q == RND_ONE) begin
          fsm_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q - RND_ONE;
        end
      end
      ST_FINAL: begin
        state_d = keyed;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Key index is 0 in DONE as well so the store address stays deterministic.
  always_comb begin
    key_idx = '0;
    case (fsm_q)
      ST_IDLE:  key_idx = KEY_FIRST;
      ST_ROUND: key_idx = rnd_q;
      default:  key_idx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= RND_START;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  // Decoded straight from the state register, so a reset in DONE drops
  // out_valid without waiting for a clock edge.
  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign out_data  = out_valid ? state_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_core
// Purpose  : Self-checking bench for aes_decrypt_core. A byte-level AES
//            reference (S-boxes derived from GF(2^8) inversion plus the
//            affine map, textbook key expansion and inverse cipher) supplies
//            the key store and the expected plaintexts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [127:0] rk [0:15];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPB_CT  = 128'h3902dc19_25dc116a_8409850b_1dfb9732;
  localparam logic [127:0] APPB_PT  = 128'h328831e0_435a3137_f6309807_a88da234;

  always #5 clk = ~clk;

  assign key_data = rk[key_idx];

  aes_decrypt_core #(.NR(10), .KIDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .key_data  (key_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int r, input int c);
    logic [6:0] lsb;
    lsb = 7'(8 * (15 - (4 * r + c)));
    return v[lsb +: 8];
  endfunction

  function automatic logic [127:0] sb(input logic [127:0] v, input int r, input int c,
                                      input logic [7:0] b);
    logic [6:0] lsb;
    lsb = 7'(8 * (15 - (4 * r + c)));
    v[lsb +: 8] = b;
    return v;
  endfunction

  // FIPS byte k (column-major string order) is row k%4, column k/4.
  function automatic logic [127:0] col2row(input logic [127:0] v);
    logic [127:0] o = '0;
    logic [6:0]   lsb;
    for (int k = 0; k < 16; k++) begin
      lsb = 7'(8 * (15 - k));
      o = sb(o, k % 4, k / 4, v[lsb +: 8]);
    end
    return o;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key_cm);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key_cm[7'(96 - 32 * i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) rk[j] = '0;
    for (int j = 0; j < 11; j++) rk[j] = col2row({w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]});
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s, n;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    s = ct ^ rk[10];
    for (int rd = 9; rd >= 0; rd--) begin
      n = s;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          n = sb(n, r, (c + r) % 4, isbox[gb(s, r, c)]);
      s = n ^ rk[rd];
      if (rd > 0) begin
        n = s;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gf_mul(coef[(k - r + 4) % 4], gb(s, k, c));
            n = sb(n, r, c, acc);
          end
        s = n;
      end
    end
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after the output handshake.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string tag);
    int k;
    in_data = ct; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_accept"}, in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    // k counts edges since accept; out_valid first seen here is handshaken
    // on the following edge, which must be edge 11.
    k = 1;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_latency"}, k, 11);
    chk({tag, "_data"}, out_data, exp);
    @(negedge clk);
    chk({tag, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  int           acc_t [2];
  int           na;
  int           k;
  logic         seen_valid;
  logic [127:0] outs [$];
  logic [127:0] ct_a, ct_b, exp_b, rkey;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    build_tables();
    expand_key(APPB_KEY);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_key_idx", key_idx, 10);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 Appendix B and C.1 known answers
    run_block(APPB_CT, APPB_PT, "appB");
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    run_block(col2row(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
              col2row(128'h00112233445566778899aabbccddeeff), "c1");

    // Key-index trace followed by output backpressure
    expand_key(APPB_KEY);
    in_data = APPB_CT; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      chk($sformatf("kidx_%0d", i), key_idx, (i <= 10) ? 10 - i : 0);
      @(negedge clk); in_valid = 1'b0;
    end
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, APPB_PT);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    chk("bp_stay_idle", {out_valid, in_ready}, 2'b01);

    // Reset five cycles after accept
    in_data = APPB_CT; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_key_idx", key_idx, 10);
    @(negedge clk); rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin @(negedge clk); seen_valid |= out_valid; end
    chk("mid_rst_no_output", seen_valid, 0);
    run_block(APPB_CT, APPB_PT, "post_rst");

    // Reset while DONE drops out_valid at once; accept on the release cycle
    in_data = APPB_CT; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk("done_reached", out_valid, 1);
    #1 rst = 1'b1; #1;
    chk("done_rst_out_valid", out_valid, 0);
    chk("done_rst_out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    run_block(APPB_CT, APPB_PT, "rst_release_accept");

    // Randomized keys and ciphertexts
    for (int i = 0; i < 6; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand_key(rkey);
      ct_a = {$urandom, $urandom, $urandom, $urandom};
      run_block(ct_a, ref_decrypt(ct_a), $sformatf("rand%0d", i));
    end

    // Back-to-back with out_ready tied high and in_valid held
    expand_key(APPB_KEY);
    ct_a = APPB_CT;
    ct_b = {$urandom, $urandom, $urandom, $urandom};
    exp_b = ref_decrypt(ct_b);
    in_data = ct_a; in_valid = 1'b1; out_ready = 1'b1; na = 0;
    for (int t = 0; t < 40; t++) begin
      if (na < 2 && in_valid && in_ready) begin acc_t[na] = t; na++; end
      if (out_valid) outs.push_back(out_data);
      @(negedge clk);
      if (na == 1) in_data = ct_b;
      if (na == 2) in_valid = 1'b0;
    end
    chk("b2b_accepts", na, 2);
    chk("b2b_spacing", (na == 2) ? acc_t[1] - acc_t[0] : -1, 12);
    chk("b2b_outputs", outs.size(), 2);
    chk("b2b_first", (outs.size() > 0) ? outs[0] : 'x, APPB_PT);
    chk("b2b_second", (outs.size() > 1) ? outs[1] : 'x, exp_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
